data_mem_responder: RTL and testbench

Word-addressed data memory that answers the load/store requests the single-cycle MIPS CPU issues for LW and SW. It sits on the memory side of a valid/ready request channel and a valid/ready response channel. It inserts a programmable number of wait states, so CPU-side stall logic can be exercised against a memory that does not answer in zero cycles. Accesses that are misaligned or outside the array are rejected with an error response and leave the array unchanged.

---
 rtl/data_mem_responder_if.sv | 20 ++
 rtl/data_mem_responder.sv | 73 +++++++
 tb/tb_data_mem_responder.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: valid/ready request and response channels between CPU and data memory
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory answering LW/SW requests after programmable wait states
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, err_q;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic [31:0]   mem_q [DEPTH_WORDS];
  logic          accept, commit, c_we, c_err;
  logic [31:0]   c_addr, c_wdata;
  logic [AW-1:0] c_idx;
  // with zero wait states the commit happens on the accepting edge, so it must see the live request
  assign accept  = state_q == IDLE && bus.req_valid;
  assign commit  = state_q != RESP && state_d == RESP;
  assign c_we    = state_q == IDLE ? bus.req_we : we_q;
  assign c_addr  = state_q == IDLE ? bus.req_addr : addr_q;
  assign c_wdata = state_q == IDLE ? bus.req_wdata : wdata_q;
  assign c_err   = c_addr[1:0] != 2'b0 || c_addr[31:AW+2] != '0;
  assign c_idx   = c_addr[AW+1:2];
  assign bus.req_ready = rst && state_q == IDLE;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  // next state: accept in IDLE, count down wait states, release on response handshake
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = WAIT_CYCLES == 0 ? RESP : WAIT;
      cnt_d   = CNT_INIT;
    end else if (state_q == WAIT) begin
      state_d = cnt_q == '0 ? RESP : WAIT;
      cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
    end else if (state_q == RESP && bus.rsp_ready) begin
      state_d = IDLE;
    end
  end
  // state, request latch, commit of the access into the array and the response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (commit) begin
        err_q   <= c_err;
        rdata_q <= (c_err || c_we) ? '0 : mem_q[c_idx];
      end
      if (commit && c_we && !c_err) mem_q[c_idx] <= c_wdata;
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed test of two responders (2 and 0 wait states) against a timing/memory model
module tb_data_mem_responder;
  typedef struct {bit we; logic [31:0] a; logic [31:0] d;} req_t;
  logic clk = 1'b0;
  logic rst;
  logic v[2], we[2], rr[2], rdy[2], vl[2], er[2];
  logic [31:0] ad[2], wd[2], rd[2];
  longint cyc = 0;
  int checks = 0, errors = 0;
  int W[2] = '{2, 0};
  bit busy[2], eerr[2], known[2], pwe[2];
  longint due[2];
  logic [31:0] erd[2], pad[2], pwd[2];
  logic [31:0] mm[int];
  req_t rq[$];
  logic [31:0] r;
  logic e;
  longint lat;

  data_mem_responder_if bus0();
  data_mem_responder_if bus1();
  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  assign bus0.req_valid = v[0];
  assign bus0.req_we    = we[0];
  assign bus0.req_addr  = ad[0];
  assign bus0.req_wdata = wd[0];
  assign bus0.rsp_ready = rr[0];
  assign rdy[0] = bus0.req_ready;
  assign vl[0]  = bus0.rsp_valid;
  assign rd[0]  = bus0.rsp_rdata;
  assign er[0]  = bus0.rsp_err;
  assign bus1.req_valid = v[1];
  assign bus1.req_we    = we[1];
  assign bus1.req_addr  = ad[1];
  assign bus1.req_wdata = wd[1];
  assign bus1.rsp_ready = rr[1];
  assign rdy[1] = bus1.req_ready;
  assign vl[1]  = bus1.rsp_valid;
  assign rd[1]  = bus1.rsp_rdata;
  assign er[1]  = bus1.rsp_err;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // model: a request accepted at edge A responds from edge A+W until the rsp_ready handshake;
  // its memory effect lands at edge A+W unless reset intervenes
  initial begin : model
    bit ev;
    int key;
    for (int d = 0; d < 2; d++) begin
      busy[d] = 0; eerr[d] = 0; known[d] = 1; erd[d] = '0; due[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst) begin
          busy[d] = 0; erd[d] = '0; eerr[d] = 0; known[d] = 1;
        end
        ev = busy[d] && cyc >= due[d];
        chk($sformatf("req_ready[%0d]", d), 32'(rdy[d]), 32'(rst && !busy[d]));
        chk($sformatf("rsp_valid[%0d]", d), 32'(vl[d]), 32'(ev));
        if (ev || !rst) begin
          chk($sformatf("rsp_err[%0d]", d), 32'(er[d]), 32'(eerr[d]));
          if (known[d]) chk($sformatf("rsp_rdata[%0d]", d), rd[d], erd[d]);
        end
        if (rst) begin
          if (ev && rr[d]) busy[d] = 0;
          else if (!busy[d] && v[d]) begin
            busy[d] = 1; due[d] = cyc + 1 + W[d];
            pwe[d] = we[d]; pad[d] = ad[d]; pwd[d] = wd[d];
          end
          if (busy[d] && due[d] == cyc + 1) begin
            eerr[d] = pad[d][1:0] != 2'b0 || pad[d][31:2] >= 30'd256;
            key = d * 4096 + int'(pad[d][11:2]);
            erd[d] = '0; known[d] = 1;
            if (!eerr[d] && pwe[d]) mm[key] = pwd[d];
            else if (!eerr[d]) begin
              known[d] = mm.exists(key);
              erd[d] = known[d] ? mm[key] : '0;
            end
          end
        end
      end
    end
  end

  task automatic xact(input int d, input bit w, input logic [31:0] a, input logic [31:0] dat,
                      input int hold, output logic [31:0] ro, output logic eo, output longint lo);
    int n;
    longint acc;
    @(posedge clk); #2;
    v[d] = 1; we[d] = w; ad[d] = a; wd[d] = dat; rr[d] = hold == 0;
    n = 0;
    @(negedge clk);
    while (!rdy[d] && n < 50) begin @(negedge clk); n++; end
    chk("accept_timeout", 32'(n >= 50), 0);
    @(posedge clk); #2;
    acc = cyc; v[d] = 0;
    n = 0;
    @(negedge clk);
    while (!vl[d] && n < 50) begin @(negedge clk); n++; end
    chk("response_timeout", 32'(n >= 50), 0);
    lo = cyc - acc + 1;
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #2 rr[d] = 1;
      @(negedge clk);
    end
    ro = rd[d]; eo = er[d];
    @(posedge clk); #2 rr[d] = 0;
  endtask

  task automatic cont(input int d, input int w);
    longint accs[$];
    bit acc;
    int t, i;
    i = 0; t = 0;
    @(posedge clk); #2;
    rr[d] = 1; v[d] = 1; we[d] = rq[0].we; ad[d] = rq[0].a; wd[d] = rq[0].d;
    while (i < rq.size() && t < 200) begin
      @(negedge clk); acc = rdy[d] && v[d];
      @(posedge clk); #2; t++;
      if (acc) begin accs.push_back(cyc); i++; end
      if (rdy[d] && i < rq.size()) begin
        we[d] = rq[i].we; ad[d] = rq[i].a; wd[d] = rq[i].d;
      end else begin
        we[d] = 1'($urandom); ad[d] = $urandom; wd[d] = $urandom;
      end
    end
    v[d] = 0;
    chk("cont_timeout", 32'(t >= 200), 0);
    chk("cont_accepts", accs.size(), rq.size());
    for (int k = 1; k < accs.size(); k++) chk("accept_spacing", 32'(accs[k] - accs[k-1]), w + 2);
    repeat (w + 3) @(posedge clk);
    #2 rr[d] = 0;
  endtask

  initial begin
    rst = 1;
    for (int d = 0; d < 2; d++) begin
      v[d] = 0; we[d] = 0; rr[d] = 0; ad[d] = '0; wd[d] = '0;
    end
    #1 rst = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1;
    xact(0, 1, 32'h10, 32'hDEADBEEF, 0, r, e, lat);
    chk("st10_err", 32'(e), 0); chk("st10_rdata", r, 0); chk("st10_latency", 32'(lat), 3);
    xact(0, 0, 32'h10, 32'h0, 0, r, e, lat);
    chk("ld10_err", 32'(e), 0); chk("ld10_rdata", r, 32'hDEADBEEF); chk("ld10_latency", 32'(lat), 3);
    xact(0, 1, 32'h3FC, 32'hC0FFEE00, 0, r, e, lat);
    chk("st3fc_err", 32'(e), 0);
    xact(0, 0, 32'h13, 32'h0, 0, r, e, lat);
    chk("misaligned_err", 32'(e), 1); chk("misaligned_rdata", r, 0);
    xact(0, 1, 32'h400, 32'h5A5A5A5A, 0, r, e, lat);
    chk("range_err", 32'(e), 1); chk("range_rdata", r, 0);
    xact(0, 0, 32'h3FC, 32'h0, 0, r, e, lat);
    chk("ld3fc_err", 32'(e), 0); chk("ld3fc_rdata", r, 32'hC0FFEE00);
    xact(0, 1, 32'h20, 32'h12345678, 5, r, e, lat);
    chk("hold_err", 32'(e), 0); chk("hold_rdata", r, 0); chk("hold_latency", 32'(lat), 3);
    xact(0, 1, 32'h8, 32'h11110008, 0, r, e, lat);
    @(posedge clk); #2;
    v[0] = 1; we[0] = 1; ad[0] = 32'h8; wd[0] = 32'hAAAA5555; rr[0] = 1;
    @(posedge clk); #2 v[0] = 0;
    @(posedge clk); #2 rst = 0;
    @(negedge clk);
    chk("abort_valid", 32'(vl[0]), 0); chk("abort_ready", 32'(rdy[0]), 0);
    @(posedge clk); #2 rst = 1; rr[0] = 0;
    xact(0, 0, 32'h8, 32'h0, 0, r, e, lat);
    chk("abort_ld8_rdata", r, 32'h11110008); chk("abort_ld8_err", 32'(e), 0);
    rq.delete();
    rq.push_back('{0, 32'h10, 32'h0});
    rq.push_back('{0, 32'h20, 32'h0});
    rq.push_back('{0, 32'h10, 32'h0});
    rq.push_back('{0, 32'h20, 32'h0});
    cont(0, 2);
    xact(1, 1, 32'h4, 32'h0BADF00D, 0, r, e, lat);
    chk("w0_st_latency", 32'(lat), 1); chk("w0_st_err", 32'(e), 0);
    xact(1, 0, 32'h4, 32'h0, 0, r, e, lat);
    chk("w0_ld_latency", 32'(lat), 1); chk("w0_ld_rdata", r, 32'h0BADF00D);
    rq.delete();
    rq.push_back('{1, 32'h4, 32'h600DCAFE});
    rq.push_back('{0, 32'h4, 32'h0});
    rq.push_back('{1, 32'h4, 32'h13579BDF});
    rq.push_back('{0, 32'h4, 32'h0});
    cont(1, 0);
    xact(1, 0, 32'h4, 32'h0, 0, r, e, lat);
    chk("w0_final_rdata", r, 32'h13579BDF);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
